// File: rtl/unified_mem_sequencer_pkg.sv
// Shared types for the unified memory sequencer: FSM states, reset NOP and
// the memory command bundle driven onto the single shared port.
package seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    DATA   = 3'd3,
    COMMIT = 3'd4,
    ERROR  = 3'd5
  } seq_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strobe;
  } mem_cmd_t;

endpackage

// File: rtl/unified_mem_sequencer_mem_wait_timer.sv
// Counts wait cycles of an outstanding memory request; flags the wait cycle
// that brings the count up to TIMEOUT.
module mem_wait_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + 1'b1;
  end

  // Fires during the TIMEOUT-th consecutive wait cycle so the FSM leaves on that edge.
  assign expired = en && (cnt == LIMIT);

endmodule

// File: rtl/unified_mem_sequencer.sv
// Multi-cycle sequencer: fetch, settle, optional data access and commit pulse,
// sharing one variable-latency memory port between instruction and data sides.
module unified_mem_sequencer
  import seq_pkg::*;
#(
  parameter int          TIMEOUT     = 255,
  parameter logic [31:0] RESET_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [31:0] InstrAddr,
  output logic [31:0] Instruction,
  input  logic [31:0] Addr,
  input  logic [31:0] WD,
  input  logic        WE,
  input  logic [3:0]  Strobe,
  input  logic        core_mem_re,
  output logic [31:0] RD,
  output logic        core_step,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_strobe,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        busy,
  output logic        err,
  output logic [31:0] retired
);

  seq_state_e state, state_nxt;
  mem_cmd_t   cmd;
  logic       tmo;

  // Request fields decode straight from state so an async reset drops them at once.
  always_comb begin
    cmd = '0;
    case (state)
      FETCH: begin
        cmd.req    = 1'b1;
        cmd.addr   = InstrAddr;
        cmd.strobe = 4'hF;
      end
      DATA: begin
        cmd.req  = 1'b1;
        cmd.addr = Addr;
        if (WE) begin
          cmd.we     = 1'b1;
          cmd.wdata  = WD;
          cmd.strobe = Strobe;
        end else begin
          cmd.strobe = 4'hF;
        end
      end
      default: cmd = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (run) state_nxt = FETCH;
      FETCH:   if (mem_ready) state_nxt = DECODE;
               else if (tmo)  state_nxt = ERROR;
      DECODE:  state_nxt = (WE || core_mem_re) ? DATA : COMMIT;
      DATA:    if (mem_ready) state_nxt = COMMIT;
               else if (tmo)  state_nxt = ERROR;
      COMMIT:  state_nxt = run ? FETCH : IDLE;
      ERROR:   state_nxt = ERROR;
      default: state_nxt = IDLE;
    endcase
  end

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (!cmd.req),
    .en      (cmd.req && !mem_ready),
    .expired (tmo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      Instruction <= RESET_INSTR;
      RD          <= '0;
      retired     <= '0;
      err         <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == FETCH && mem_ready)
        Instruction <= mem_rdata;
      if (state == DATA && mem_ready && !WE && core_mem_re)
        RD <= mem_rdata;
      if (state == COMMIT)
        retired <= retired + 32'd1;
      if (tmo)
        err <= 1'b1;
    end
  end

  assign mem_req    = cmd.req;
  assign mem_addr   = cmd.addr;
  assign mem_we     = cmd.we;
  assign mem_wdata  = cmd.wdata;
  assign mem_strobe = cmd.strobe;
  assign core_step  = (state == COMMIT);
  assign busy       = (state != IDLE) && (state != ERROR);

endmodule

// File: tb/tb_unified_mem_sequencer.sv
// Directed + randomized bench: each instruction is expanded into its expected
// phase sequence (fetch waits, settle, data waits, commit) and checked per cycle.
module tb_unified_mem_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [31:0] InstrAddr, Instruction, Addr, WD, RD, mem_addr, mem_wdata, mem_rdata, retired;
  logic        WE, core_mem_re, core_step, mem_req, mem_we, mem_ready, busy, err;
  logic [3:0]  Strobe, mem_strobe;

  int          passed = 0;
  int          total  = 0;
  int          fails  = 0;
  logic [31:0] exp_ret = 0;
  logic [31:0] exp_rd  = 0;

  always #5 clk = ~clk;

  unified_mem_sequencer #(.TIMEOUT(4), .RESET_INSTR(32'h0000_0013)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .InstrAddr(InstrAddr), .Instruction(Instruction),
    .Addr(Addr), .WD(WD), .WE(WE), .Strobe(Strobe), .core_mem_re(core_mem_re),
    .RD(RD), .core_step(core_step),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_strobe(mem_strobe), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .err(err), .retired(retired)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Entered one cycle into FETCH (just after the edge); leaves just after the edge ending COMMIT.
  task automatic do_instr(input logic [31:0] ia, input logic [31:0] ins, input logic w, input logic r,
                          input logic [31:0] a, input logic [31:0] d, input logic [3:0] sb,
                          input int fw, input int dw, input logic [31:0] rdat, input logic run_after);
    InstrAddr = ia; Addr = a; WD = d; WE = w; core_mem_re = r; Strobe = sb;
    for (int k = 0; k <= fw; k++) begin
      mem_ready = (k == fw);
      mem_rdata = (k == fw) ? ins : $urandom;
      @(negedge clk);
      chk("fetch_req", mem_req, 1);
      chk("fetch_addr", mem_addr, ia);
      chk("fetch_we", mem_we, 0);
      chk("fetch_strobe", mem_strobe, 32'hF);
      chk("fetch_step", core_step, 0);
      chk("fetch_busy", busy, 1);
      tick;
    end
    mem_ready = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    @(negedge clk);
    chk("decode_req", mem_req, 0);
    chk("decode_addr", mem_addr, 0);
    chk("decode_instr", Instruction, ins);
    chk("decode_step", core_step, 0);
    tick;
    if (w || r) begin
      run = run_after;
      for (int k = 0; k <= dw; k++) begin
        mem_ready = (k == dw);
        mem_rdata = (k == dw) ? rdat : $urandom;
        @(negedge clk);
        chk("data_req", mem_req, 1);
        chk("data_addr", mem_addr, a);
        chk("data_we", mem_we, {31'd0, w});
        if (w) begin
          chk("data_wdata", mem_wdata, d);
          chk("data_strobe", mem_strobe, {28'd0, sb});
        end
        chk("data_step", core_step, 0);
        tick;
      end
    end
    run = run_after;
    mem_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("commit_step", core_step, 1);
    chk("commit_req", mem_req, 0);
    chk("commit_busy", busy, 1);
    tick;
    exp_ret = exp_ret + 1;
    if (r && !w) exp_rd = rdat;
    chk("retired", retired, exp_ret);
    chk("rd", RD, exp_rd);
    chk("instr_hold", Instruction, ins);
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; InstrAddr = '0; Addr = '0; WD = '0; WE = 1'b0;
    core_mem_re = 1'b0; Strobe = '0; mem_rdata = '0; mem_ready = 1'b0;
    repeat (2) tick;
    chk("rst_req", mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_step", core_step, 0);
    chk("rst_instr", Instruction, 32'h0000_0013);
    chk("rst_rd", RD, 0);
    chk("rst_retired", retired, 0);
    chk("rst_addr", mem_addr, 0);
    rst_n = 1'b1;

    // IDLE cycle with a stray ready that must be ignored
    run = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    chk("idle_req", mem_req, 0);
    chk("idle_busy", busy, 0);
    tick;

    do_instr(32'h0, 32'h00500093, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0, 1'b1);
    do_instr(32'h4, 32'h10002083, 1'b0, 1'b1, 32'h100, 32'h0, 4'hF, 0, 2, 32'hDEADBEEF, 1'b1);
    do_instr(32'h8, 32'h20102023, 1'b1, 1'b0, 32'h200, 32'h12345678, 4'b0011, 1, 0, 32'h0, 1'b1);
    do_instr(32'hC, 32'h00000033, 1'b1, 1'b1, 32'h300, 32'hCAFEF00D, 4'b1100, 0, 1, 32'h55AA55AA, 1'b1);
    do_instr(32'h10, 32'h0000006F, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3, 0, 32'h0, 1'b1);

    for (int i = 0; i < 24; i++) begin
      do_instr({$urandom_range(0, 1023), 2'b00}, $urandom,
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               $urandom, $urandom, 4'($urandom_range(0, 15)),
               $urandom_range(0, 3), $urandom_range(0, 3), $urandom, 1'b1);
    end

    // run dropped during the data phase: the load still completes, then IDLE
    do_instr(32'h40, 32'h00002103, 1'b0, 1'b1, 32'h400, 32'h0, 4'hF, 0, 1, 32'h0BADC0DE, 1'b0);
    for (int k = 0; k < 3; k++) begin
      mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("stop_req", mem_req, 0);
      chk("stop_busy", busy, 0);
      chk("stop_step", core_step, 0);
      tick;
    end
    chk("stop_retired", retired, exp_ret);

    // reset in the middle of a fetch drops the request immediately
    run = 1'b1; mem_ready = 1'b0;
    tick;
    @(negedge clk);
    chk("abort_req_before", mem_req, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_req_after", mem_req, 0);
    chk("abort_retired", retired, 0);
    exp_ret = 0; exp_rd = 0;
    tick;
    rst_n = 1'b1;

    // timeout: TIMEOUT=4 wait cycles in FETCH lead to ERROR
    tick;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("tmo_req", mem_req, 1);
      chk("tmo_err_pending", err, 0);
      tick;
    end
    for (int k = 0; k < 3; k++) begin
      mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("err_flag", err, 1);
      chk("err_req", mem_req, 0);
      chk("err_busy", busy, 0);
      chk("err_step", core_step, 0);
      tick;
    end
    chk("err_retired", retired, 0);
    rst_n = 1'b0; run = 1'b0;
    #1;
    chk("clr_err", err, 0);
    chk("clr_busy", busy, 0);
    chk("clr_instr", Instruction, 32'h0000_0013);
    tick;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_req", mem_req, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/unified_mem_sequencer.md
# unified_mem_sequencer

Multi-cycle sequencer that lets the RV32I core run from a single shared memory port with variable-latency handshake. It fetches the instruction, holds it stable for the core, performs at most one data access, then issues a one-cycle `core_step` commit pulse. Sits between the core's instruction and data ports and the single memory port. The core uses `core_step` as the clock enable for its PC and register-file updates.

## Interface
- `TIMEOUT`, default 255: max cycles a memory request may wait for `mem_ready` before error.
- `RESET_INSTR`, default 32'h0000_0013: instruction-register reset value (NOP).
- `clk`  in  1  system clock
- `rst_n`  in  1  reset; one clock, asynchronous, active-low
- `run`  in  1  level; 1 = execute instructions, 0 = stop after current instruction
- `InstrAddr`  in  32  core PC (fetch address)
- `Instruction`  out  32  registered instruction presented to core
- `Addr`  in  32  core data address
- `WD`  in  32  core store data
- `WE`  in  1  core store request
- `Strobe`  in  4  core byte strobes
- `core_mem_re`  in  1  core load request
- `RD`  out  32  registered load data to core
- `core_step`  out  1  one-cycle commit pulse
- `mem_req`  out  1  memory request, held until `mem_ready`
- `mem_addr`  out  32  memory address
- `mem_we`  out  1  memory write
- `mem_wdata`  out  32  memory write data
- `mem_strobe`  out  4  memory byte strobes (4'hF on fetch)
- `mem_rdata`  in  32  memory read data, valid with `mem_ready`
- `mem_ready`  in  1  memory completion
- `busy`  out  1  state != IDLE and != ERROR
- `err`  out  1  sticky timeout flag
- `retired`  out  32  count of `core_step` pulses, wraps at 2^32

## Operation
- States: IDLE, FETCH, DECODE, DATA, COMMIT, ERROR.
- IDLE: all requests low. If `run`=1, go to FETCH.
- FETCH: `mem_req`=1, `mem_addr`=`InstrAddr`, `mem_we`=0, `mem_strobe`=4'hF. On `mem_ready`: latch `mem_rdata` into `Instruction`, go to DECODE.
- DECODE: one cycle for core combinational settling. Sample `WE`/`core_mem_re`:
  - if either is 1, go to DATA;
  - otherwise go to COMMIT.
- DATA: `mem_req`=1, `mem_addr`=`Addr`. If `WE`=1, then `mem_we`=1, `mem_wdata`=`WD`, `mem_strobe`=`Strobe`; `WE` takes precedence over `core_mem_re` when both are set. On `mem_ready`: for a load, latch `mem_rdata` into `RD`. Go to COMMIT.
- COMMIT: `core_step`=1 for exactly this cycle; `retired` increments. Then:
  - if `run`=1, go to FETCH;
  - otherwise go to IDLE.
- `mem_addr`/`mem_we`/`mem_wdata`/`mem_strobe` are driven to 0 whenever `mem_req`=0.
- Timeout: a wait counter clears on entry to FETCH/DATA and increments each cycle `mem_req`=1 and `mem_ready`=0. If it reaches `TIMEOUT`: set `err`, go to ERROR, no `core_step`. ERROR is left only by reset.
- `run` is sampled only in IDLE and COMMIT. Deasserting it mid-instruction never aborts the access.
- `RD` holds its value across non-load instructions.
- `Instruction` holds until the next fetch completes.

## Timing
- Reset (async assert, sync release) values:
  - state = IDLE;
  - `Instruction` = `RESET_INSTR`;
  - `RD` = 0, `retired` = 0;
  - `core_step`, `mem_req`, `mem_we`, `busy`, `err` = 0;
  - `mem_addr`, `mem_wdata`, `mem_strobe` = 0.
- Zero-wait memory (`mem_ready` in the same cycle as `mem_req`):
  - non-memory instruction: 3 cycles (FETCH, DECODE, COMMIT);
  - load or store: 4 cycles.
- Each wait cycle on `mem_ready` adds one cycle.
- `mem_ready` while `mem_req`=0 is ignored.
- First `mem_req` rises one cycle after `run` is seen high in IDLE.
- Reset mid-access drops `mem_req` immediately. The memory must tolerate an abandoned request.
- `retired` updates on the same edge that ends the COMMIT cycle.

## Structure
- A shared package `seq_pkg` holds:
  - the state enum (IDLE=0, FETCH=1, DECODE=2, DATA=3, COMMIT=4, ERROR=5);
  - `NOP_INSTR` = 32'h0000_0013.
- One sub-module, `mem_wait_timer`: counter with clear/enable inputs and a `TIMEOUT`-compare output. The FSM, request muxing and latches stay in the top module.

## Test plan
- Reset then `run`=1, zero-wait memory returning 32'h00500093 → `mem_req` in cycles 1–3 is 1,0,0 and `core_step` in cycle 3; `retired`=1; `Instruction`=32'h00500093.
- Load (`core_mem_re`=1, `Addr`=0x100), `mem_rdata`=0xDEADBEEF after 2 wait cycles → `RD`=0xDEADBEEF; `core_step` 6 cycles after fetch start.
- Store with `Strobe`=4'b0011, `WD`=0x12345678, `Addr`=0x200 → one DATA cycle with `mem_we`=1, `mem_strobe`=4'b0011, `mem_addr`=0x200, `mem_wdata`=0x12345678.
- Both `WE` and `core_mem_re` = 1 → write performed; `RD` unchanged.
- `run` dropped during DATA → access completes, one `core_step`, then IDLE with `busy`=0 and no further `mem_req`.
- `mem_ready` held 0 with `TIMEOUT`=4 → `err`=1 after 4 wait cycles; `mem_req`=0; no `core_step`; `rst_n` pulse clears `err` and returns to IDLE.
